// File: rtl/bcd_serial_sub.sv
// Digit-serial packed-BCD subtractor giving |A-B| plus a negative flag, one digit per clock, LSD first.
// Latency start->done: 1 (illegal digit), DIGITS+1 (A>=B), 2*DIGITS+1 (A<B); start is ignored while busy.
module bcd_serial_sub #(
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [4*DIGITS-1:0]   A,
  input  logic [4*DIGITS-1:0]   B,
  output logic [4*DIGITS-1:0]   D,
  output logic                  bo,
  output logic                  err,
  output logic                  busy,
  output logic                  done
);

  localparam int W  = 4 * DIGITS;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic [1:0] {S_IDLE, S_SUB, S_NEG, S_FIN} state_t;

  state_t          r_state;
  logic [W-1:0]    r_a;
  logic [W-1:0]    r_b;
  logic [W-1:0]    r_r;
  logic [IW-1:0]   r_idx;
  logic            r_brw;

  logic            w_illegal;
  logic [3:0]      w_min;
  logic [3:0]      w_sub;
  logic [4:0]      w_t;
  logic            w_bout;
  logic [3:0]      w_dig;
  logic [W-1:0]    w_r_next;
  logic            w_last;

  always_comb begin
    w_illegal = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (A[4*i +: 4] > 4'd9 || B[4*i +: 4] > 4'd9) w_illegal = 1'b1;
    end
  end

  // One digit slice shared by both passes; the NEG pass subtracts r from zero (ten's complement).
  always_comb begin
    w_min    = (r_state == S_NEG) ? 4'd0 : r_a[{r_idx, 2'b00} +: 4];
    w_sub    = (r_state == S_NEG) ? r_r[{r_idx, 2'b00} +: 4] : r_b[{r_idx, 2'b00} +: 4];
    w_t      = {1'b0, w_min} - {1'b0, w_sub} - {4'b0000, r_brw};
    w_bout   = w_t[4];
    w_dig    = w_bout ? (w_t[3:0] + 4'd10) : w_t[3:0];
    w_r_next = r_r;
    w_r_next[{r_idx, 2'b00} +: 4] = w_dig;
    w_last   = (r_idx == IW'(DIGITS - 1));
  end

  assign busy = (r_state != S_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_r     <= '0;
      r_idx   <= '0;
      r_brw   <= 1'b0;
      D       <= '0;
      bo      <= 1'b0;
      err     <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_a   <= A;
            r_b   <= B;
            r_r   <= '0;
            r_idx <= '0;
            r_brw <= 1'b0;
            if (w_illegal) begin
              D       <= '1;
              bo      <= 1'b0;
              err     <= 1'b1;
              done    <= 1'b1;
              r_state <= S_FIN;
            end else begin
              r_state <= S_SUB;
            end
          end
        end
        S_SUB: begin
          r_r <= w_r_next;
          if (w_last) begin
            r_idx <= '0;
            r_brw <= 1'b0;
            if (w_bout) begin
              r_state <= S_NEG;
            end else begin
              D       <= w_r_next;
              bo      <= 1'b0;
              err     <= 1'b0;
              done    <= 1'b1;
              r_state <= S_FIN;
            end
          end else begin
            r_idx <= r_idx + IW'(1);
            r_brw <= w_bout;
          end
        end
        S_NEG: begin
          r_r <= w_r_next;
          if (w_last) begin
            r_idx   <= '0;
            r_brw   <= 1'b0;
            D       <= w_r_next;
            bo      <= 1'b1;
            err     <= 1'b0;
            done    <= 1'b1;
            r_state <= S_FIN;
          end else begin
            r_idx <= r_idx + IW'(1);
            r_brw <= w_bout;
          end
        end
        S_FIN: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_serial_sub.sv
// Bench for bcd_serial_sub: decimal reference model with per-cycle compare, directed vectors and random back-to-back ops.
module tb_bcd_serial_sub;

  localparam int DIGITS = 4;
  localparam int W      = 4 * DIGITS;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b1;
  logic          start = 1'b0;
  logic [W-1:0]  A     = '0;
  logic [W-1:0]  B     = '0;
  logic [W-1:0]  D;
  logic          bo;
  logic          err;
  logic          busy;
  logic          done;

  int n_cmp = 0;
  int n_bad = 0;

  int           m_k    = 0;
  int           m_lat  = 0;
  logic [W-1:0] m_D    = '0;
  logic [W-1:0] m_pD   = '0;
  logic         m_bo   = 1'b0;
  logic         m_pbo  = 1'b0;
  logic         m_err  = 1'b0;
  logic         m_perr = 1'b0;

  bcd_serial_sub #(.DIGITS(DIGITS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .A     (A),
    .B     (B),
    .D     (D),
    .bo    (bo),
    .err   (err),
    .busy  (busy),
    .done  (done)
  );

  always #5 clk = ~clk;

  function automatic int bcd2int(input logic [W-1:0] v);
    int r = 0;
    for (int i = DIGITS - 1; i >= 0; i--) r = r * 10 + int'(v[4*i +: 4]);
    return r;
  endfunction

  function automatic logic [W-1:0] int2bcd(input int n);
    logic [W-1:0] r = '0;
    int x = n;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic bit has_illegal(input logic [W-1:0] a, input logic [W-1:0] b);
    bit bad = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (a[4*i +: 4] > 4'd9 || b[4*i +: 4] > 4'd9) bad = 1'b1;
    end
    return bad;
  endfunction

  function automatic void model_accept(input logic [W-1:0] a, input logic [W-1:0] b);
    int ia, ib;
    if (has_illegal(a, b)) begin
      m_pD   = '1;
      m_pbo  = 1'b0;
      m_perr = 1'b1;
      m_lat  = 1;
    end else begin
      ia     = bcd2int(a);
      ib     = bcd2int(b);
      m_pD   = int2bcd((ia >= ib) ? (ia - ib) : (ib - ia));
      m_pbo  = (ia < ib);
      m_perr = 1'b0;
      m_lat  = m_pbo ? (2 * DIGITS + 1) : (DIGITS + 1);
    end
  endfunction

  // m_k = cycles since the accepting edge (0 = idle); results appear in cycle m_lat.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_k   = 0;
      m_D   = '0;
      m_bo  = 1'b0;
      m_err = 1'b0;
    end else begin
      if (m_k == 0) begin
        if (start) begin
          model_accept(A, B);
          m_k = 1;
        end
      end else if (m_k == m_lat) begin
        m_k = 0;
      end else begin
        m_k++;
      end
      if (m_k != 0 && m_k == m_lat) begin
        m_D   = m_pD;
        m_bo  = m_pbo;
        m_err = m_perr;
      end
    end
  end

  task automatic check(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    check("busy", W'(busy), W'(m_k != 0));
    check("done", W'(done), W'(m_k != 0 && m_k == m_lat));
    check("D",    D,        m_D);
    check("bo",   W'(bo),   W'(m_bo));
    check("err",  W'(err),  W'(m_err));
  end

  // mode 0: plain op; 1: extra start pulse during SUB; 2: reset asserted in cycle 3.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] exp_d, input logic exp_bo, input logic exp_err,
                        input int exp_lat, input int mode, input string nm);
    int seen = 0;
    @(negedge clk);
    A = a;
    B = b;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int cyc = 1; cyc <= 30; cyc++) begin
      if (done === 1'b1) begin
        seen = cyc;
        break;
      end
      if (mode == 1 && cyc == 2) begin
        A = 16'h0000;
        B = 16'h0001;
        start = 1'b1;
      end
      if (mode == 1 && cyc == 3) start = 1'b0;
      if (mode == 2 && cyc == 3) begin
        #2 rst_n = 1'b0;
        #1;
        check({nm, "_rst_D"},    D,         16'h0000);
        check({nm, "_rst_bo"},   W'(bo),    16'h0000);
        check({nm, "_rst_err"},  W'(err),   16'h0000);
        check({nm, "_rst_busy"}, W'(busy),  16'h0000);
        check({nm, "_rst_done"}, W'(done),  16'h0000);
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b1;
        return;
      end
      @(negedge clk);
    end
    check({nm, "_lat"}, W'(seen),   W'(exp_lat));
    check({nm, "_D"},   D,          exp_d);
    check({nm, "_bo"},  W'(bo),     W'(exp_bo));
    check({nm, "_err"}, W'(err),    W'(exp_err));
  endtask

  function automatic logic [W-1:0] rand_bcd();
    logic [W-1:0] v = '0;
    for (int i = 0; i < DIGITS; i++) v[4*i +: 4] = 4'($urandom_range(0, 9));
    if ($urandom_range(0, 31) == 0) v[4*$urandom_range(0, DIGITS-1) +: 4] = 4'($urandom_range(10, 15));
    return v;
  endfunction

  initial begin
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;

    run_op(16'h1234, 16'h0567, 16'h0667, 1'b0, 1'b0, 5, 0, "pos");
    run_op(16'h0100, 16'h0101, 16'h0001, 1'b1, 1'b0, 9, 0, "neg");
    run_op(16'h0000, 16'h9999, 16'h9999, 1'b1, 1'b0, 9, 0, "zero_m");
    run_op(16'h9999, 16'h9999, 16'h0000, 1'b0, 1'b0, 5, 0, "equal");
    run_op(16'h12A4, 16'h0001, 16'hFFFF, 1'b0, 1'b1, 1, 0, "illegal");
    run_op(16'h0005, 16'h0003, 16'h0002, 1'b0, 1'b0, 5, 0, "clr_err");
    run_op(16'h4321, 16'h1234, 16'h3087, 1'b0, 1'b0, 5, 1, "ign_start");
    run_op(16'h5000, 16'h0001, 16'h4999, 1'b0, 1'b0, 5, 2, "abort");
    run_op(16'h0010, 16'h0100, 16'h0090, 1'b1, 1'b0, 9, 0, "after_rst");

    for (int n = 0; n < 600; n++) begin
      @(negedge clk);
      start = ($urandom_range(0, 3) != 0);
      A = rand_bcd();
      B = rand_bcd();
    end
    @(negedge clk);
    start = 1'b0;
    repeat (2 * DIGITS + 4) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
